// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared types for the cache maintenance sequencer.
package cache_ctrl_pkg;
    typedef logic [3:0] cache_op_mask_t;
    localparam int OP_DFLUSH = 0;
    localparam int OP_DCLEAR = 1;
    localparam int OP_IFLUSH = 2;
    localparam int OP_ICLEAR = 3;
    typedef enum logic [2:0] {IDLE, DFLUSH, DCLEAR, IFLUSH, ICLEAR, DONE} seq_state_t;
    // Step state k handles mask bit k-1, so the lowest set bit at or above lo is the next step.
    function automatic seq_state_t next_step(cache_op_mask_t m, logic [2:0] lo);
        next_step = DONE;
        for (int i = 3; i >= 0; i--)
            if (m[i] && 3'(i) >= lo) next_step = seq_state_t'(3'(i + 1));
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: level request / done handshakes between the pipeline and the caches.
interface cache_ctrl_if;
    logic dcache_flush, dcache_clear, icache_flush, icache_clear;
    logic dflush_done, dclear_done, iflush_done, iclear_done;
    logic dcache_reserve, dcache_exclusive;
    modport master (
        output dcache_flush, dcache_clear, icache_flush, icache_clear, dcache_reserve, dcache_exclusive,
        input  dflush_done, dclear_done, iflush_done, iclear_done
    );
    modport slave (
        input  dcache_flush, dcache_clear, icache_flush, icache_clear, dcache_reserve, dcache_exclusive,
        output dflush_done, dclear_done, iflush_done, iclear_done
    );
endinterface

// File: rtl/cache_ctrl_watchdog.sv
// cache_ctrl_watchdog: per-step cycle counter; expired flags the last allowed cycle of a step.
module cache_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
    always_comb cnt_d = clr ? '0 : expired ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/cache_ctrl_sequencer.sv
// cache_ctrl_sequencer: runs a masked dflush/dclear/iflush/iclear sequence and pulses seq_done.
// Define CACHE_SEQ_TIMEOUT_EN to bound each step by TIMEOUT_CYCLES and report seq_err.
module cache_ctrl_sequencer
    import cache_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           req_valid,
    input  cache_op_mask_t req_ops,
    output logic           req_ready,
    output logic           seq_done,
    output logic           seq_err,
    output logic           busy,
    input  logic           lr_req,
    input  logic           sc_req,
    cache_ctrl_if.master   cif
);
    seq_state_t state_q, state_d;
    cache_op_mask_t mask_q, mask_d, done_vec;
    logic step, cur_done, expired;
    assign done_vec[OP_DFLUSH] = cif.dflush_done;
    assign done_vec[OP_DCLEAR] = cif.dclear_done;
    assign done_vec[OP_IFLUSH] = cif.iflush_done;
    assign done_vec[OP_ICLEAR] = cif.iclear_done;
    assign step = state_q inside {DFLUSH, DCLEAR, IFLUSH, ICLEAR};
    assign cur_done = step && done_vec[2'(state_q - 3'd1)];
    always_comb begin
        state_d = state_q;
        mask_d = mask_q;
        if (state_q == IDLE && req_valid) begin
            mask_d = req_ops;
            state_d = next_step(req_ops, 3'd0);
        end else if (cur_done) state_d = next_step(mask_q, state_q);
        else if (step && expired) state_d = DONE;
        else if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state_q <= IDLE;
            mask_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
        end
`ifdef CACHE_SEQ_TIMEOUT_EN
    logic err_q, err_d;
    cache_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .CLK(CLK), .nRST(nRST), .clr(state_d != state_q), .expired(expired)
    );
    // A done on the expiry cycle takes the normal path, so no error is latched then.
    always_comb err_d = (state_q == IDLE) ? 1'b0 : (step && !cur_done && expired) ? 1'b1 : err_q;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) err_q <= 1'b0;
        else err_q <= err_d;
    assign seq_err = seq_done && err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expired = 1'b0;
    assign seq_err = 1'b0;
`endif
    assign req_ready = state_q == IDLE;
    assign busy = !req_ready;
    assign seq_done = state_q == DONE;
    assign cif.dcache_flush = state_q == DFLUSH;
    assign cif.dcache_clear = state_q == DCLEAR;
    assign cif.icache_flush = state_q == IFLUSH;
    assign cif.icache_clear = state_q == ICLEAR;
    assign cif.dcache_reserve = sc_req && !busy;
    assign cif.dcache_exclusive = lr_req && !busy;
endmodule

// File: tb/tb_cache_ctrl_sequencer.sv
// tb_cache_ctrl_sequencer: scoreboard bench; cache responders answer after a set delay or hold done high.
module tb_cache_ctrl_sequencer;
    localparam int TO = 8;
    logic CLK = 1'b0, nRST = 1'b0, req_valid = 1'b0, lr_req = 1'b0, sc_req = 1'b0;
    logic [3:0] req_ops = '0;
    logic req_ready, seq_done, seq_err, busy;
    logic [3:0] req, prev = '0;
    logic tie = 1'b0;
    int dly[4] = '{1000, 1000, 1000, 1000};
    int rcnt[4] = '{0, 0, 0, 0};
    int hi[4] = '{0, 0, 0, 0};
    int checks = 0, errors = 0;
    typedef struct {int code; int len; logic err;} exp_t;
    exp_t sb[$];

    cache_ctrl_if cif();
    cache_ctrl_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ops(req_ops), .req_ready(req_ready),
        .seq_done(seq_done), .seq_err(seq_err), .busy(busy), .lr_req(lr_req), .sc_req(sc_req),
        .cif(cif.master)
    );
    always #5 CLK = ~CLK;
    assign req = {cif.icache_clear, cif.icache_flush, cif.dcache_clear, cif.dcache_flush};

    always @(negedge CLK) begin : responder
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            if (tie) d[i] = 1'b1;
            else if (req[i]) begin
                d[i] = rcnt[i] >= dly[i];
                rcnt[i]++;
            end else begin
                d[i] = 1'b0;
                rcnt[i] = 0;
            end
        end
        {cif.iclear_done, cif.iflush_done, cif.dclear_done, cif.dflush_done} = d;
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!nRST) begin
            prev = '0;
            for (int i = 0; i < 4; i++) hi[i] = 0;
        end else begin
            checks++;
            if ($countones(req) > 1 || (seq_err && !seq_done)) begin
                errors++;
                $display("FAIL exclusive_outputs req=%b seq_err=%b seq_done=%b, want one-hot req and err only with done", req, seq_err, seq_done);
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i]) hi[i]++;
                else if (prev[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_step got step %0d len %0d, want no step", i, hi[i]);
                    end else begin
                        e = sb.pop_front();
                        if (e.code != i || e.len != hi[i]) begin
                            errors++;
                            $display("FAIL step_order got step %0d len %0d, want step %0d len %0d", i, hi[i], e.code, e.len);
                        end
                    end
                    hi[i] = 0;
                end
            end
            if (seq_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got seq_done err=%b, want none", seq_err);
                end else begin
                    e = sb.pop_front();
                    if (e.code != 4 || e.err !== seq_err) begin
                        errors++;
                        $display("FAIL done_event got done err=%b, want code %0d err=%b", seq_err, e.code, e.err);
                    end
                end
            end
            prev = req;
        end
    end

    task automatic push_steps(input logic [3:0] ops);
        for (int i = 0; i < 4; i++)
            if (ops[i]) sb.push_back('{code: i, len: tie ? 1 : dly[i] + 1, err: 1'b0});
    endtask

    task automatic push_done(input logic err);
        sb.push_back('{code: 4, len: 0, err: err});
    endtask

    task automatic issue(input logic [3:0] ops, output int n);
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_ops = ops;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_ops = 4'($urandom);
        n = 0;
        repeat (3000) begin
            @(negedge CLK);
            n++;
            if (seq_done) break;
        end
        if (!seq_done) begin
            errors++;
            $display("FAIL done_timeout got no seq_done after %0d cycles, want completion", n);
        end
    endtask

    task automatic drain(input string name);
        repeat (100) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending events, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({req_ready, busy, seq_done, seq_err, req} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs got %b, want 10000000", {req_ready, busy, seq_done, seq_err, req});
        end
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b, want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_two_step;
        int n;
        dly = '{3, 1000, 1000, 2};
        push_steps(4'b1001);
        push_done(1'b0);
        issue(4'b1001, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL two_step_latency got %0d, want 8", n);
        end
        drain("two_step");
    endtask

    task automatic test_empty;
        int n;
        push_done(1'b0);
        issue(4'b0000, n);
        checks++;
        if (n + 1 != 2) begin
            errors++;
            $display("FAIL empty_done_cycle got %0d, want 2", n + 1);
        end
        drain("empty");
    endtask

    task automatic test_all_tied;
        int n;
        tie = 1'b1;
        push_steps(4'b1111);
        push_done(1'b0);
        issue(4'b1111, n);
        checks++;
        if (n + 1 != 6) begin
            errors++;
            $display("FAIL tied_done_cycle got %0d, want 6", n + 1);
        end
        drain("tied");
        tie = 1'b0;
    endtask

    task automatic test_reset_mid;
        dly = '{1000, 1000, 1000, 1000};
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_ops = 4'b0010;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        checks++;
        if (cif.dcache_clear !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_high got %b, want 1", cif.dcache_clear);
        end
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({req, seq_done, busy, seq_err} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b, want 0000000", {req, seq_done, busy, seq_err});
        end
        @(posedge CLK);
        #2 nRST = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %b, want 1", req_ready);
        end
        drain("reset_mid");
    endtask

`ifdef CACHE_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        dly = '{1000, 1000, 1000, 1000};
        sb.push_back('{code: 0, len: TO, err: 1'b0});
        push_done(1'b1);
        issue(4'b0011, n);
        checks++;
        if (n != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d, want %0d", n, TO + 1);
        end
        drain("timeout");
    endtask
`endif

    task automatic test_hints_busy;
        lr_req = 1'b1;
        #1;
        checks++;
        if (cif.dcache_exclusive !== 1'b1 || cif.dcache_reserve !== 1'b0) begin
            errors++;
            $display("FAIL idle_lr got excl=%b resv=%b, want 1 0", cif.dcache_exclusive, cif.dcache_reserve);
        end
        sc_req = 1'b1;
        #1;
        checks++;
        if (cif.dcache_reserve !== 1'b1) begin
            errors++;
            $display("FAIL idle_sc got %b, want 1", cif.dcache_reserve);
        end
        dly = '{5, 1000, 1000, 1000};
        push_steps(4'b0001);
        push_done(1'b0);
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_ops = 4'b0001;
        @(posedge CLK); #1;
        req_ops = 4'b1111;
        checks++;
        if ({cif.dcache_exclusive, cif.dcache_reserve, busy, req_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL busy_hints got %b, want 0010", {cif.dcache_exclusive, cif.dcache_reserve, busy, req_ready});
        end
        repeat (2) @(posedge CLK);
        #1 req_valid = 1'b0;
        drain("hints_busy");
        repeat (6) @(negedge CLK);
        lr_req = 1'b0;
        sc_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat;
        push_done(1'b0);
        push_done(1'b0);
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_ops = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            pat[k] = seq_done;
        end
        req_valid = 1'b0;
        checks++;
        if (pat !== 4'b0101) begin
            errors++;
            $display("FAIL back_to_back got %b, want 0101", pat);
        end
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_two_step();
        test_empty();
        test_all_tied();
        test_reset_mid();
`ifdef CACHE_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_hints_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
